axi_wr_arbiter: RTL
===================

// Module: axi_wr_arbiter
// PURPOSE
//  Shares one AXI3 slave write port (AW/W/B) among NUM_M masters, one transaction at a time.
//  Round-robin grant on AW; W beats and the B response stay locked to the granted master
//  until the B handshake completes. Sits between the master-side interconnect and the
//  Slave_Write block (awlen/awaddr/wlast/bresp semantics per the slave write ILA).
// PARAMETERS
//  NUM_M    2     number of masters (2..4)
//  ID_W     12    AXI ID width (awid/wid/bid)
//  TO_CYC   255   watchdog limit in cycles without handshake while in DATA/RESP (1..255)
// PORTS
//  clk          in   1          clock
//  rst          in   1          reset, synchronous, active-high
//  m_awvalid    in   NUM_M      per-master AW valid
//  m_awready    out  NUM_M      per-master AW ready
//  m_awaddr     in   NUM_M*32   AW address, master i at [32*i+:32]
//  m_awlen      in   NUM_M*8    burst length-1
//  m_awsize     in   NUM_M*3    beat size
//  m_awburst    in   NUM_M*2    burst type
//  m_awid       in   NUM_M*ID_W transaction ID
//  m_wvalid     in   NUM_M      W valid
//  m_wready     out  NUM_M      W ready
//  m_wdata      in   NUM_M*32   write data
//  m_wstrb      in   NUM_M*4    byte strobes
//  m_wlast      in   NUM_M      last beat
//  m_wid        in   NUM_M*ID_W W ID (AXI3)
//  m_bvalid     out  NUM_M      B valid
//  m_bready     in   NUM_M      B ready
//  m_bresp      out  2          B response (broadcast; qualify with m_bvalid)
//  m_bid        out  ID_W       B ID (broadcast)
//  s_aw{valid,addr,len,size,burst,id}  out  1/32/8/3/2/ID_W   slave AW channel
//  s_awready    in   1          slave AW ready
//  s_w{valid,data,strb,last,id}        out  1/32/4/1/ID_W     slave W channel
//  s_wready     in   1          slave W ready
//  s_bvalid     in   1          slave B valid
//  s_bresp      in   2          slave B response
//  s_bid        in   ID_W       slave B ID
//  s_bready     out  1          slave B ready
//  grant        out  2          index of granted master (valid when busy=1)
//  busy         out  1          state != IDLE
//  err_wlast    out  1          sticky: wlast beat count mismatch
//  err_timeout  out  1          sticky: watchdog expired
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, wd_cnt=0; all *valid/*ready outputs 0,
//   err_* 0. Mid-transaction reset abandons the transaction; no handshake outputs on cycle after.
//  IDLE: no m_awready. If any m_awvalid: pick first i in order rr_ptr, rr_ptr+1,.. (mod NUM_M);
//   register grant=i, go ADDR. 1 cycle latency from m_awvalid to s_awvalid.
//  ADDR: s_aw* = master[grant] payload; s_awvalid=m_awvalid[grant]; m_awready[grant]=s_awready.
//   On handshake: latch len_q=awlen, beat_cnt=0, go DATA.
//  DATA: s_w* = master[grant]; m_wready[grant]=s_wready. Each handshake: beat_cnt+=1 (8-bit).
//   Handshake with wlast=1 -> RESP; if beat_cnt!=len_q at that beat, set err_wlast.
//   Beat beat_cnt==len_q without wlast: set err_wlast, keep forwarding until wlast.
//  RESP: m_bvalid[grant]=s_bvalid; s_bready=m_bready[grant]; m_bresp/m_bid=s_bresp/s_bid.
//   On handshake: rr_ptr=(grant+1) mod NUM_M, go IDLE. No AW accepted in same cycle.
//  Non-granted masters: awready/wready/bvalid held 0 in all states.
//  Watchdog: wd_cnt clears on any handshake or state change; in DATA/RESP increments, and
//   at wd_cnt==TO_CYC sets err_timeout (state unchanged; recovery only via rst).
//  All forwarding paths are combinational on registered grant/state; no data buffering.
// STRUCTURE
//  Package axi_arb_pkg: state enum {IDLE,ADDR,DATA,RESP}, BURST_FIXED/INCR/WRAP,
//   RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
//  Sub-module rr_pick: combinational NUM_M-way round-robin picker (req, ptr -> idx, any).
// TESTING
//  M0,M1 awvalid same cycle, rr_ptr=0 -> M0 granted; after its B, M1 granted next.
//  M1 awlen=3, INCR: 4 W beats, wlast on 4th -> RESP, err_wlast=0, s_wvalid pulses=4.
//  awlen=1 but wlast on beat 1 -> err_wlast=1, state RESP after that beat.
//  s_bvalid=1 with m_bready[grant]=0 for 3 cycles -> stays RESP, m_bvalid held, no regrant.
//  s_wready=0 for TO_CYC cycles in DATA -> err_timeout=1 at cycle TO_CYC.
//  rst asserted in DATA -> next cycle busy=0, all ready/valid outputs 0, rr_ptr=0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI3 write-port arbiter.
package axi_arb_pkg;

    // Arbiter transaction phase: waiting, address, data beats, response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester found when scanning
// upward from ptr_i (wrapping modulo NUM_M) wins.
module rr_pick #(
    parameter int NUM_M = 2
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [1:0]       idx_o,
    output logic             any_o
);

    // Scan offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        int j;
        j     = 0;
        idx_o = 2'd0;
        any_o = |req_i;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NUM_M;
            if (req_i[j]) begin
                idx_o = 2'(j);
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI3 slave write port among NUM_M masters, one transaction at a
// time. AW is granted round-robin; W and B stay locked to the granted master
// until the B handshake completes.
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and every forwarded valid/ready is a
// combinational function of the registered state and grant only.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ID_W   = 12,
    parameter int TO_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_M-1:0]      m_awvalid,
    output logic [NUM_M-1:0]      m_awready,
    input  logic [NUM_M*32-1:0]   m_awaddr,
    input  logic [NUM_M*8-1:0]    m_awlen,
    input  logic [NUM_M*3-1:0]    m_awsize,
    input  logic [NUM_M*2-1:0]    m_awburst,
    input  logic [NUM_M*ID_W-1:0] m_awid,
    input  logic [NUM_M-1:0]      m_wvalid,
    output logic [NUM_M-1:0]      m_wready,
    input  logic [NUM_M*32-1:0]   m_wdata,
    input  logic [NUM_M*4-1:0]    m_wstrb,
    input  logic [NUM_M-1:0]      m_wlast,
    input  logic [NUM_M*ID_W-1:0] m_wid,
    output logic [NUM_M-1:0]      m_bvalid,
    input  logic [NUM_M-1:0]      m_bready,
    output logic [1:0]            m_bresp,
    output logic [ID_W-1:0]       m_bid,
    output logic                  s_awvalid,
    output logic [31:0]           s_awaddr,
    output logic [7:0]            s_awlen,
    output logic [2:0]            s_awsize,
    output logic [1:0]            s_awburst,
    output logic [ID_W-1:0]       s_awid,
    input  logic                  s_awready,
    output logic                  s_wvalid,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    output logic                  s_wlast,
    output logic [ID_W-1:0]       s_wid,
    input  logic                  s_wready,
    input  logic                  s_bvalid,
    input  logic [1:0]            s_bresp,
    input  logic [ID_W-1:0]       s_bid,
    output logic                  s_bready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  err_wlast,
    output logic                  err_timeout,
    output logic [1:0]            dbg_state
);

    arb_state_t       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [7:0]       wd_cnt_q, wd_cnt_d;
    logic             err_wlast_q, err_wlast_d;
    logic             err_timeout_q, err_timeout_d;

    logic [NUM_M-1:0] grant_oh;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic             sel_awvalid, sel_wvalid, sel_bready;
    logic             hs;

    rr_pick #(.NUM_M(NUM_M)) u_pick (
        .req_i (m_awvalid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Select the granted master's payload onto the slave side.
    always_comb begin
        grant_oh    = '0;
        sel_awvalid = 1'b0;
        sel_wvalid  = 1'b0;
        sel_bready  = 1'b0;
        s_awaddr    = '0;
        s_awlen     = '0;
        s_awsize    = '0;
        s_awburst   = '0;
        s_awid      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wlast     = 1'b0;
        s_wid       = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q == 2'(i)) begin
                grant_oh[i] = 1'b1;
                sel_awvalid = m_awvalid[i];
                sel_wvalid  = m_wvalid[i];
                sel_bready  = m_bready[i];
                s_awaddr    = m_awaddr[32*i +: 32];
                s_awlen     = m_awlen[8*i +: 8];
                s_awsize    = m_awsize[3*i +: 3];
                s_awburst   = m_awburst[2*i +: 2];
                s_awid      = m_awid[ID_W*i +: ID_W];
                s_wdata     = m_wdata[32*i +: 32];
                s_wstrb     = m_wstrb[4*i +: 4];
                s_wlast     = m_wlast[i];
                s_wid       = m_wid[ID_W*i +: ID_W];
            end
        end
    end

    // Next-state, handshake gating, beat check and watchdog.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        err_wlast_d   = err_wlast_q;
        err_timeout_d = err_timeout_q;
        hs            = 1'b0;
        s_awvalid     = 1'b0;
        s_wvalid      = 1'b0;
        s_bready      = 1'b0;
        m_awready     = '0;
        m_wready      = '0;
        m_bvalid      = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_awvalid = sel_awvalid;
                m_awready = grant_oh & {NUM_M{s_awready}};
                if (sel_awvalid && s_awready) begin
                    hs         = 1'b1;
                    len_d      = s_awlen;
                    beat_cnt_d = 8'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                s_wvalid = sel_wvalid;
                m_wready = grant_oh & {NUM_M{s_wready}};
                if (sel_wvalid && s_wready) begin
                    hs         = 1'b1;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (s_wlast) begin
                        state_d = RESP;
                        if (beat_cnt_q != len_q) err_wlast_d = 1'b1;
                    end else if (beat_cnt_q == len_q) begin
                        err_wlast_d = 1'b1;
                    end
                end
            end
            RESP: begin
                m_bvalid = grant_oh & {NUM_M{s_bvalid}};
                s_bready = sel_bready;
                if (s_bvalid && sel_bready) begin
                    hs       = 1'b1;
                    rr_ptr_d = (grant_q == 2'(NUM_M - 1)) ? 2'd0 : grant_q + 2'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog counts idle cycles of an open data/response phase and saturates.
        if ((state_q == DATA || state_q == RESP) && !hs && state_d == state_q) begin
            wd_cnt_d = (wd_cnt_q == 8'(TO_CYC)) ? wd_cnt_q : wd_cnt_q + 8'd1;
            if (wd_cnt_d == 8'(TO_CYC)) err_timeout_d = 1'b1;
        end else begin
            wd_cnt_d = 8'd0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 2'd0;
            rr_ptr_q      <= 2'd0;
            len_q         <= 8'd0;
            beat_cnt_q    <= 8'd0;
            wd_cnt_q      <= 8'd0;
            err_wlast_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            err_wlast_q   <= err_wlast_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign m_bresp     = s_bresp;
    assign m_bid       = s_bid;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign err_wlast   = err_wlast_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

endmodule
